// File: rtl/oam_dma_periph.sv
// ----------------------------------------------------------------------------
// oam_dma_periph
//   Object Attribute Memory (OAM) with a CPU access port, a bulk DMA copy
//   engine and a combinational PPU read port.
//
//   Writing a value V to the DMA trigger register copies OAM_DEPTH bytes from
//   source address {V, 8'h00} into OAM, one entry every BYTE_CYCLES clocks.
//   While the copy runs, CPU access to OAM is blocked (reads return all-ones,
//   writes are dropped). OAM contents survive reset.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cpu_addr   in   CPU access address
//   cpu_wdata  in   CPU write data
//   cpu_we     in   CPU write strobe
//   cpu_re     in   CPU read strobe
//   cpu_rdata  out  registered read data (one cycle after cpu_re)
//   cpu_hit    out  registered: previous-cycle access decoded to OAM/DMA_REG
//   src_addr   out  DMA source read address
//   src_re     out  DMA source read strobe
//   src_rdata  in   source data, valid one clock after src_re
//   ppu_idx    in   PPU OAM index
//   ppu_rdata  out  combinational OAM[ppu_idx], all-ones when out of range
//   dma_busy   out  high while a transfer is in progress
// ----------------------------------------------------------------------------
module oam_dma_periph #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned OAM_BASE    = 16'hFE00,
    parameter int unsigned OAM_DEPTH   = 160,
    parameter int unsigned DMA_REG     = 16'hFF46,
    parameter int unsigned BYTE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic [ADDR_W-1:0] src_addr,
    output logic              src_re,
    input  logic [DATA_W-1:0] src_rdata,
    input  logic [7:0]        ppu_idx,
    output logic [DATA_W-1:0] ppu_rdata,
    output logic              dma_busy
);

    localparam int unsigned     CYC_W    = $clog2(BYTE_CYCLES);
    localparam int unsigned     AW1      = ADDR_W + 1;
    // One extra bit so OAM_BASE+OAM_DEPTH cannot wrap at the top of the map
    localparam logic [AW1-1:0]  OAM_LO   = AW1'(OAM_BASE);
    localparam logic [AW1-1:0]  OAM_HI   = AW1'(OAM_BASE + OAM_DEPTH);
    localparam logic [ADDR_W-1:0] REG_ADDR = ADDR_W'(DMA_REG);
    localparam logic [7:0]      LAST_IDX = 8'(OAM_DEPTH - 1);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(BYTE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    // Storage and state
    logic [DATA_W-1:0] r_oam [OAM_DEPTH];
    state_t            r_state;
    logic [7:0]        r_idx;
    logic [CYC_W-1:0]  r_cyc;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_src_addr;
    logic              r_src_re;
    logic              r_busy;
    logic [DATA_W-1:0] r_dma_reg;
    logic [DATA_W-1:0] r_rdata;
    logic              r_hit;

    // Decode
    logic              w_oam_hit;
    logic              w_reg_hit;
    logic [7:0]        w_oam_idx;
    logic              w_reg_we;
    logic              w_cpu_oam_we;
    logic              w_dma_oam_we;
    logic              w_last_cyc;
    logic [ADDR_W-1:0] w_new_base;

    assign w_oam_hit    = ({1'b0, cpu_addr} >= OAM_LO) && ({1'b0, cpu_addr} < OAM_HI);
    assign w_reg_hit    = (cpu_addr == REG_ADDR);
    assign w_oam_idx    = 8'(cpu_addr - ADDR_W'(OAM_BASE));
    assign w_reg_we     = cpu_we && w_reg_hit;
    assign w_cpu_oam_we = cpu_we && w_oam_hit && (r_state == IDLE);
    assign w_dma_oam_we = (r_state == XFER) && (r_cyc == CYC_W'(1));
    assign w_last_cyc   = (r_cyc == LAST_CYC);
    assign w_new_base   = ADDR_W'({cpu_wdata, 8'h00});

    // ------------------------------------------------------------------
    // DMA sequencer. src_re/src_addr are registered, so they are loaded on
    // the edge that enters cyc==0 (start, restart or byte wrap).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cyc      <= '0;
            r_base     <= '0;
            r_src_addr <= '0;
            r_src_re   <= 1'b0;
            r_busy     <= 1'b0;
            r_dma_reg  <= '0;
        end else begin
            r_src_re <= 1'b0;
            if (w_reg_we) begin
                // Trigger (or restart) takes priority over any step in flight
                r_dma_reg  <= cpu_wdata;
                r_base     <= w_new_base;
                r_state    <= XFER;
                r_busy     <= 1'b1;
                r_idx      <= '0;
                r_cyc      <= '0;
                r_src_re   <= 1'b1;
                r_src_addr <= w_new_base;
            end else if (r_state == XFER) begin
                if (w_last_cyc) begin
                    r_cyc <= '0;
                    if (r_idx == LAST_IDX) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                    end else begin
                        r_idx      <= r_idx + 8'd1;
                        r_src_re   <= 1'b1;
                        r_src_addr <= r_base + ADDR_W'(r_idx + 8'd1);
                    end
                end else begin
                    r_cyc <= r_cyc + CYC_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // OAM array: deliberately not reset. DMA and CPU writes are mutually
    // exclusive because CPU writes are only accepted while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_dma_oam_we) begin
            r_oam[r_idx] <= src_rdata;
        end else if (w_cpu_oam_we) begin
            r_oam[w_oam_idx] <= cpu_wdata;
        end
    end

    // ------------------------------------------------------------------
    // CPU read/hit response, one cycle after the access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else if (cpu_re && w_oam_hit) begin
            r_hit   <= 1'b1;
            r_rdata <= (r_state == XFER) ? '1 : r_oam[w_oam_idx];
        end else if (cpu_re && w_reg_hit) begin
            r_hit   <= 1'b1;
            r_rdata <= r_dma_reg;
        end else begin
            r_hit   <= cpu_we && (w_oam_hit || w_reg_hit);
            r_rdata <= '0;
        end
    end

    assign ppu_rdata = (32'(ppu_idx) < OAM_DEPTH) ? r_oam[ppu_idx] : '1;
    assign cpu_rdata = r_rdata;
    assign cpu_hit   = r_hit;
    assign src_addr  = r_src_addr;
    assign src_re    = r_src_re;
    assign dma_busy  = r_busy;

endmodule

// File: tb/tb_oam_dma_periph.sv
module tb_oam_dma_periph;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [7:0]  cpu_rdata;
    logic        cpu_hit;
    logic [15:0] src_addr;
    logic        src_re;
    logic [7:0]  src_rdata;
    logic [7:0]  ppu_idx;
    logic [7:0]  ppu_rdata;
    logic        dma_busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic src_mode;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic        re;
        logic [7:0]  exp_rdata;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [12];

    oam_dma_periph #(
        .DATA_W     (8),
        .ADDR_W     (16),
        .OAM_BASE   (16'hFE00),
        .OAM_DEPTH  (160),
        .DMA_REG    (16'hFF46),
        .BYTE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_we   (cpu_we),
        .cpu_re   (cpu_re),
        .cpu_rdata(cpu_rdata),
        .cpu_hit  (cpu_hit),
        .src_addr (src_addr),
        .src_re   (src_re),
        .src_rdata(src_rdata),
        .ppu_idx  (ppu_idx),
        .ppu_rdata(ppu_rdata),
        .dma_busy (dma_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory model: mode 0 returns addr low byte, mode 1 low^high
    always @(posedge clk) begin
        if (src_re)
            src_rdata <= src_mode ? (src_addr[7:0] ^ src_addr[15:8]) : src_addr[7:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        step();
        cpu_we    = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        cpu_addr = a;
        cpu_re   = 1'b1;
        step();
        cpu_re   = 1'b0;
    endtask

    task automatic check_oam(input string name, input int lo, input int hi, input logic [7:0] xorv);
        int errs;
        logic [7:0] iv;
        errs = 0;
        for (int i = lo; i < hi; i++) begin
            iv      = 8'(i);
            ppu_idx = iv;
            #1;
            if (ppu_rdata !== (iv ^ xorv)) errs++;
        end
        chk(name, errs, 0);
    endtask

    // Trigger a transfer with v0; optionally rewrite DMA_REG with v1 in busy
    // cycle rt. Checks src_re/src_addr cadence each cycle and returns the
    // number of consecutive busy cycles observed.
    task automatic run_xfer(input logic [7:0] v0, input int rt, input logic [7:0] v1,
                            input bit probe, output int busy_cnt, output int addr_err);
        int          t;
        int          seg_start;
        logic [15:0] seg_base;
        logic [15:0] pend_base;
        bit          pend;
        addr_err = 0;
        cpu_write(16'hFF46, v0);
        t         = 0;
        seg_start = 0;
        seg_base  = {v0, 8'h00};
        pend_base = '0;
        pend      = 1'b0;
        while (dma_busy === 1'b1 && t < 4000) begin
            if (src_re !== (((t - seg_start) % 4) == 0))
                addr_err++;
            else if (src_re && src_addr !== seg_base + 16'((t - seg_start) / 4))
                addr_err++;
            if (probe && t == 101)
                chk("busy_oam_read", {cpu_hit, cpu_rdata}, {1'b1, 8'hFF});
            if (t == rt) begin
                cpu_addr  = 16'hFF46;
                cpu_wdata = v1;
                cpu_we    = 1'b1;
                pend      = 1'b1;
                pend_base = {v1, 8'h00};
            end
            if (probe && t == 100) begin
                cpu_addr = 16'hFE05;
                cpu_re   = 1'b1;
            end
            if (probe && t == 200) begin
                cpu_addr  = 16'hFE05;
                cpu_wdata = 8'h12;
                cpu_we    = 1'b1;
            end
            step();
            cpu_we = 1'b0;
            cpu_re = 1'b0;
            t++;
            if (pend) begin
                seg_start = t;
                seg_base  = pend_base;
                pend      = 1'b0;
            end
        end
        busy_cnt = t;
    endtask

    initial begin
        int          bc;
        int          ae;
        int          errs;
        int          w;
        logic [15:0] a;
        logic [7:0]  d;

        rst_n     = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
        ppu_idx   = '0;
        src_mode  = 1'b0;

        vecs[0]  = '{16'hFE00, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{16'hFE9F, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{16'hFEA0, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{16'hFE05, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{16'hFE00, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1};
        vecs[5]  = '{16'hFE9F, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1};
        vecs[6]  = '{16'hFEA0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[7]  = '{16'hFDFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[8]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[9]  = '{16'hFE05, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1};
        vecs[10] = '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
        vecs[11] = '{16'hFF47, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};

        // Reset state
        repeat (3) step();
        chk("rst_busy",     dma_busy,  0);
        chk("rst_src_re",   src_re,    0);
        chk("rst_src_addr", src_addr,  0);
        chk("rst_rdata",    cpu_rdata, 0);
        chk("rst_hit",      cpu_hit,   0);
        rst_n = 1'b1;
        step();

        // Idle CPU access table
        for (int i = 0; i < 12; i++) begin
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            cpu_we    = vecs[i].we;
            cpu_re    = vecs[i].re;
            step();
            cpu_we = 1'b0;
            cpu_re = 1'b0;
            if (vecs[i].re)
                chk($sformatf("vec%0d", i), {cpu_hit, cpu_rdata}, {vecs[i].exp_hit, vecs[i].exp_rdata});
        end

        ppu_idx = 8'd0;   #1; chk("ppu_idx0",   ppu_rdata, 8'h11);
        ppu_idx = 8'd159; #1; chk("ppu_idx159", ppu_rdata, 8'h22);
        ppu_idx = 8'd160; #1; chk("ppu_idx160", ppu_rdata, 8'hFF);
        ppu_idx = 8'd200; #1; chk("ppu_idx200", ppu_rdata, 8'hFF);

        // Idle write/read-back loop
        errs = 0;
        for (int i = 0; i < 900; i++) begin
            a = 16'hFE00 + 16'(i % 160);
            d = 8'($urandom);
            cpu_write(a, d);
            cpu_read(a);
            if ({cpu_hit, cpu_rdata} !== {1'b1, d}) errs++;
        end
        chk("idle_loop_errs", errs, 0);

        // Plain transfer from C000 with CPU probes while busy
        src_mode = 1'b0;
        run_xfer(8'hC0, -1, 8'h00, 1'b1, bc, ae);
        chk("xfer_c0_busy", bc, 640);
        chk("xfer_c0_addr", ae, 0);
        check_oam("oam_c0", 0, 160, 8'h00);
        ppu_idx = 8'd5; #1;
        chk("oam5_ignores_cpu", ppu_rdata, 8'h05);
        cpu_read(16'hFF46);
        chk("dmareg_c0", {cpu_hit, cpu_rdata}, {1'b1, 8'hC0});

        // Restart mid-transfer at idx 50
        src_mode = 1'b1;
        run_xfer(8'hC0, 200, 8'hD0, 1'b0, bc, ae);
        chk("restart_busy", bc, 841);
        chk("restart_addr", ae, 0);
        check_oam("oam_d0", 0, 160, 8'hD0);

        // Restart on the final transfer cycle: no gap in busy
        run_xfer(8'h10, 639, 8'hE0, 1'b0, bc, ae);
        chk("final_restart_busy", bc, 1280);
        chk("final_restart_addr", ae, 0);
        check_oam("oam_e0", 0, 160, 8'hE0);

        // Reset mid-transfer at idx 80
        src_mode = 1'b0;
        cpu_write(16'hFF46, 8'hC0);
        repeat (320) step();
        chk("pre_rst_src_re",   src_re,   1);
        chk("pre_rst_src_addr", src_addr, 16'hC050);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy",     dma_busy, 0);
        chk("async_rst_src_re",   src_re,   0);
        chk("async_rst_src_addr", src_addr, 0);
        repeat (2) step();
        rst_n = 1'b1;
        check_oam("oam_after_rst_copied", 0, 80, 8'h00);
        check_oam("oam_after_rst_kept", 80, 160, 8'hE0);
        cpu_read(16'hFF46);
        chk("dmareg_after_rst", {cpu_hit, cpu_rdata}, {1'b1, 8'h00});

        // Register readback, unmapped read, out-of-range PPU index
        cpu_write(16'hFF46, 8'h3A);
        cpu_read(16'hFF46);
        chk("dmareg_3a", {cpu_hit, cpu_rdata}, {1'b1, 8'h3A});
        cpu_read(16'h0000);
        chk("unmapped_read", {cpu_hit, cpu_rdata}, {1'b0, 8'h00});
        ppu_idx = 8'd200; #1;
        chk("ppu_oob", ppu_rdata, 8'hFF);
        w = 0;
        while (dma_busy === 1'b1 && w < 2000) begin
            step();
            w++;
        end
        chk("final_idle", dma_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma_periph.md
OAM_DMA_PERIPH -- requirements
Module: oam_dma_periph

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bus data width.
REQ-002 SHALL have parameter ADDR_W, default 16: bus address width.
REQ-003 SHALL have parameter OAM_BASE, default 16'hFE00: first OAM address.
REQ-004 SHALL have parameter OAM_DEPTH, default 160: OAM entries, range 1..256.
REQ-005 SHALL have parameter DMA_REG, default 16'hFF46: DMA trigger register address.
REQ-006 SHALL have parameter BYTE_CYCLES, default 4: clocks per transferred entry, minimum 2.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-008 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-009 SHALL have port cpu_addr, input, ADDR_W: CPU access address.
REQ-010 SHALL have port cpu_wdata, input, DATA_W: CPU write data.
REQ-011 SHALL have port cpu_we, input, 1: CPU write strobe.
REQ-012 SHALL have port cpu_re, input, 1: CPU read strobe.
REQ-013 SHALL have port cpu_rdata, output, DATA_W: registered read data.
REQ-014 SHALL have port cpu_hit, output, 1: registered; previous-cycle access decoded to OAM or DMA_REG.
REQ-015 SHALL have port src_addr, output, ADDR_W: DMA source read address.
REQ-016 SHALL have port src_re, output, 1: DMA source read strobe.
REQ-017 SHALL have port src_rdata, input, DATA_W: source data, valid one clock after src_re.
REQ-018 SHALL have port ppu_idx, input, 8: PPU OAM index.
REQ-019 SHALL have port ppu_rdata, output, DATA_W: combinational OAM[ppu_idx]; all-ones if ppu_idx >= OAM_DEPTH.
REQ-020 SHALL have port dma_busy, output, 1: high while a transfer is in progress.

Function
REQ-021 An OAM hit is defined as OAM_BASE <= cpu_addr < OAM_BASE+OAM_DEPTH; a register hit is cpu_addr == DMA_REG.
REQ-022 When idle, a CPU write on an OAM hit SHALL store cpu_wdata at index cpu_addr-OAM_BASE.
REQ-023 A CPU read SHALL present data on cpu_rdata and assert cpu_hit one cycle after cpu_re. An OAM hit returns the entry. A register hit returns the last value written to DMA_REG. A miss returns 0 with cpu_hit=0.
REQ-024 While dma_busy, CPU OAM writes SHALL be ignored and CPU OAM reads SHALL return all-ones with cpu_hit=1.
REQ-025 The FSM SHALL have states IDLE and XFER, with byte index idx (0..OAM_DEPTH-1) and phase counter cyc (0..BYTE_CYCLES-1).
REQ-026 A CPU write of V to DMA_REG SHALL latch V and set base = {V, 8'h00} truncated to ADDR_W. Next cycle: state=XFER, idx=0, cyc=0, dma_busy=1.
REQ-027 In XFER at cyc==0, src_re SHALL be 1 for that cycle only, with src_addr = base+idx (mod 2^ADDR_W); otherwise src_re=0 and src_addr holds.
REQ-028 In XFER at cyc==1, OAM[idx] SHALL be written with src_rdata.
REQ-029 At cyc==BYTE_CYCLES-1, cyc SHALL wrap to 0 and idx SHALL increment. If idx==OAM_DEPTH-1, state SHALL return to IDLE and dma_busy SHALL drop.
REQ-030 dma_busy SHALL be high for exactly OAM_DEPTH*BYTE_CYCLES consecutive cycles per uninterrupted transfer.
REQ-031 A DMA_REG write during XFER SHALL restart the transfer: new base, idx=0, cyc=0 next cycle. Entries already copied are not rolled back.
REQ-032 A DMA_REG write coinciding with the final transfer cycle SHALL start a new transfer, with dma_busy staying high with no gap.
REQ-033 ppu_rdata SHALL reflect OAM writes from the cycle after the write edge, including DMA writes.

Reset
REQ-034 rst_n low SHALL immediately force state=IDLE, idx=0, cyc=0, dma_busy=0, src_re=0, src_addr=0, cpu_rdata=0, cpu_hit=0, and DMA_REG value=0.
REQ-035 OAM contents SHALL NOT be cleared by reset. Reset mid-transfer aborts it, keeping all entries already written.

Verification
REQ-036 Idle CPU OAM loop: write random byte to OAM_BASE+(i mod OAM_DEPTH) for 900 iterations, read back -> every read matches, cpu_hit=1.
REQ-037 Write 8'hC0 to DMA_REG with source model returning low byte of address -> src_addr steps C000..C09F every 4 cycles; busy=640 cycles; OAM[i]==i.
REQ-038 CPU read OAM_BASE+5 during transfer -> 8'hFF; CPU write 8'h12 to OAM_BASE+5 during transfer -> OAM[5] reflects the DMA value only.
REQ-039 Write 8'hC0, then 8'hD0 at idx=50 -> src_addr jumps to D000; busy continues another 640 cycles; OAM[0..159] holds D0xx data.
REQ-040 Assert rst_n=0 at idx=80 -> dma_busy=0 and src_re=0 immediately; OAM[0..79] hold copied data; DMA_REG reads 0.
REQ-041 Read DMA_REG after writing 8'h3A -> 8'h3A; read unmapped address 16'h0000 -> 0 with cpu_hit=0; ppu_idx=200 -> ppu_rdata=8'hFF.
